bram_loader: RTL and testbench
==============================

// Module: bram_loader
// PURPOSE
//  Download sequencer that feeds the 8-bit boot/cart BRAM from the HPS ioctl stream.
//  Filters by ioctl_index, strips a file header and range-checks each byte.
//  Buffers bytes in a small FIFO and drives the BRAM init write port with back-pressure.
//  Holds the CPU in reset until every byte is committed, then signals completion.
// PARAMETERS
//  INDEX        8'd1     ioctl_index value this loader accepts
//  HEADER_BYTES 0        leading file bytes discarded (offset = ioctl_addr - HEADER_BYTES)
//  BASE_ADDR    16'h0000 BRAM address of file offset 0
//  MAX_BYTES    513      accepted payload bytes; offsets >= MAX_BYTES are errors
//  FIFO_DEPTH   4        entries of {addr[15:0],data[7:0]}; power of 2, >= 4
// PORTS
//  clk               in   1   core clock; sole clock
//  reset             in   1   asynchronous, active-high reset
//  ioctl_download    in   1   HPS download window
//  ioctl_index       in   8   file index
//  ioctl_wr          in   1   one-cycle byte strobe
//  ioctl_addr        in   25  byte offset in file
//  ioctl_dout        in   8   byte data
//  ioctl_wait        out  1   back-pressure to HPS
//  bram_download     out  1   BRAM init-port enable
//  bram_wr           out  1   BRAM write request
//  bram_init_address out  16  BRAM write address
//  bram_din          out  8   BRAM write data
//  bram_ready        in   1   write accepted this cycle when bram_wr=1
//  cpu_hold          out  1   hold CPU in reset while loading
//  load_done         out  1   one-cycle pulse after final commit
//  load_error        out  1   sticky: out-of-range byte or FIFO overflow
//  byte_count        out  16  bytes committed to BRAM, saturates at 16'hFFFF
//  checksum          out  8   mod-256 sum of committed bytes
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; state IDLE. Reset mid-load abandons the load silently.
//  - States: IDLE, LOAD, FLUSH, DONE.
//  - IDLE -> LOAD when ioctl_download=1 and ioctl_index==INDEX.
//    Clears byte_count, checksum and load_error; sets cpu_hold=1 and bram_download=1.
//    An index mismatch is ignored; stay in IDLE with ioctl_wait=0.
//  - LOAD: ioctl_wr is registered once (input stage), then classified:
//    ioctl_addr < HEADER_BYTES: dropped.
//    offset >= MAX_BYTES: dropped, load_error=1.
//    otherwise: push {BASE_ADDR+offset[15:0], data}. Address add wraps mod 2^16.
//  - Push while FIFO full: byte dropped, load_error=1.
//  - ioctl_wait=1 when FIFO count + input-stage valid >= FIFO_DEPTH-1, so an in-flight strobe always fits.
//  - Drain: bram_wr=1 whenever FIFO non-empty; address/data come from the head.
//    Pop on bram_wr && bram_ready; on that cycle byte_count++ (saturating) and checksum += data.
//    Simultaneous push and pop are allowed; count is unchanged.
//  - Latency: ioctl_wr at cycle N -> FIFO write at N+1 -> bram_wr earliest N+2.
//    Throughput is 1 byte/clk when bram_ready=1.
//  - LOAD -> FLUSH on ioctl_download=0. In FLUSH, ioctl_wait=1 and any pending input-stage byte is still pushed.
//  - FLUSH -> DONE when the FIFO and input stage are empty. DONE: load_done=1 for one cycle; bram_download=0.
//  - DONE -> IDLE next cycle; cpu_hold drops in that same cycle.
//  - ioctl_download reasserting in FLUSH/DONE is not seen until IDLE.
//  - load_error does not abort the load; it clears only on reset or the next IDLE->LOAD.
// STRUCTURE
//  - studio2_pkg: loader state localparams and the LOADER_IDX_* index constants.
//  - Sub-module sync_fifo (WIDTH=24, DEPTH=FIFO_DEPTH): full/empty/count, same-cycle push+pop.
//  - FSM, input stage, range check, and counter/checksum logic live in bram_loader.
// TESTING
//  - Index 1, 4 bytes 11,22,33,44 at addr 0..3, bram_ready=1 -> writes at 0..3;
//    byte_count=4, checksum=8'hAA, load_done pulse, cpu_hold falls.
//  - HEADER_BYTES=2, BASE_ADDR=16'h0100, bytes at addr 0..3 -> only 2 writes,
//    at 16'h0100 and 16'h0101.
//  - bram_ready=0 for 20 cycles with continuous ioctl_wr -> ioctl_wait rises within
//    FIFO_DEPTH-1 bytes; no byte lost; load_error=0.
//  - Byte at offset 513 (MAX_BYTES=513) -> no bram_wr for it; load_error=1; load_done still pulses.
//  - Index 2 download -> no bram_wr, cpu_hold=0, ioctl_wait=0 throughout.
//  - reset asserted with 3 bytes queued -> all outputs 0 asynchronously;
//    a subsequent full load completes normally.

Source files
------------

// File: rtl/studio2_pkg.sv
// Shared constants and types for the boot/cart BRAM loader.
package studio2_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] LOADER_IDX_ROM  = 8'd1;
    localparam logic [7:0] LOADER_IDX_CART = 8'd2;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } bram_entry_t;

    localparam int ENTRY_W = $bits(bram_entry_t);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push and pop may coincide, overfull pushes and empty pops are ignored.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; empty/count gate every use of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_loader.sv
// Feeds the 8-bit boot/cart BRAM init port from the HPS ioctl download stream,
// holding the CPU in reset until every accepted byte has been committed.
module bram_loader
    import studio2_pkg::*;
#(
    parameter logic [7:0]  INDEX        = LOADER_IDX_ROM,
    parameter int          HEADER_BYTES = 0,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int          MAX_BYTES    = 513,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        bram_download,
    output logic        bram_wr,
    output logic [15:0] bram_init_address,
    output logic [7:0]  bram_din,
    input  logic        bram_ready,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] byte_count,
    output logic [7:0]  checksum
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state;
    logic          in_vld;
    logic [24:0]   in_addr;
    logic [7:0]    in_data;
    logic [24:0]   offset;
    logic          in_hdr;
    logic          in_oor;
    logic          push_req;
    logic          pop;
    logic          start;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    bram_entry_t   push_entry;
    bram_entry_t   head;

    assign start  = (state == ST_IDLE) && ioctl_download && (ioctl_index == INDEX);
    assign offset = in_addr - 25'(HEADER_BYTES);

    generate
        if (HEADER_BYTES == 0) begin : g_nohdr
            assign in_hdr = 1'b0;
        end else begin : g_hdr
            assign in_hdr = (in_addr < 25'(HEADER_BYTES));
        end
    endgenerate

    assign in_oor          = !in_hdr && (offset >= 25'(MAX_BYTES));
    assign push_req        = in_vld && !in_hdr && !in_oor;
    assign push_entry.addr = BASE_ADDR + offset[15:0];
    assign push_entry.data = in_data;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head fields are masked so the port reads zero while nothing is queued.
    assign bram_wr           = !fifo_empty;
    assign pop               = bram_wr && bram_ready;
    assign bram_init_address = bram_wr ? head.addr : 16'h0000;
    assign bram_din          = bram_wr ? head.data : 8'h00;
    assign load_done         = (state == ST_DONE);

    // One slot of headroom so a strobe already in flight when wait rises still fits.
    always_comb begin
        ioctl_wait = 1'b0;
        case (state)
            ST_LOAD:  ioctl_wait = (({1'b0, fifo_count} + {{CW{1'b0}}, in_vld})
                                    >= (CW+1)'(FIFO_DEPTH - 1));
            ST_FLUSH: ioctl_wait = 1'b1;
            default:  ioctl_wait = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            in_vld        <= 1'b0;
            in_addr       <= '0;
            in_data       <= '0;
            cpu_hold      <= 1'b0;
            bram_download <= 1'b0;
            load_error    <= 1'b0;
            byte_count    <= '0;
            checksum      <= '0;
        end else begin
            in_vld <= (state == ST_LOAD) && ioctl_wr;
            if (ioctl_wr) begin
                in_addr <= ioctl_addr;
                in_data <= ioctl_dout;
            end

            if (pop) begin
                byte_count <= sat_inc16(byte_count);
                checksum   <= checksum + head.data;
            end

            if ((in_vld && in_oor) || (push_req && fifo_full))
                load_error <= 1'b1;

            case (state)
                ST_IDLE: if (start) begin
                    state         <= ST_LOAD;
                    cpu_hold      <= 1'b1;
                    bram_download <= 1'b1;
                    byte_count    <= '0;
                    checksum      <= '0;
                    load_error    <= 1'b0;
                end
                ST_LOAD: if (!ioctl_download) state <= ST_FLUSH;
                ST_FLUSH: if (fifo_empty && !in_vld) begin
                    state         <= ST_DONE;
                    bram_download <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: single-byte download table plus multi-cycle sequences.
module tb_bram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        download;
    logic [7:0]  index;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        ready;

    logic        a_wait, a_bdl, a_wr, a_hold, a_done, a_err;
    logic [15:0] a_addr, a_bc;
    logic [7:0]  a_din, a_cks;
    logic        b_wait, b_bdl, b_wr, b_hold, b_done, b_err;
    logic [15:0] b_addr, b_bc;
    logic [7:0]  b_din, b_cks;

    int total = 0;
    int bad   = 0;

    logic [23:0] wq_a[$];
    logic [23:0] wq_b[$];
    int          done_a = 0;
    logic        hold_seen = 1'b0;
    logic        wait_seen = 1'b0;

    always #5 clk = ~clk;

    bram_loader #(.INDEX(8'd1), .HEADER_BYTES(0), .BASE_ADDR(16'h0000), .MAX_BYTES(513), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .ioctl_download(download), .ioctl_index(index),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(a_wait),
        .bram_download(a_bdl), .bram_wr(a_wr), .bram_init_address(a_addr), .bram_din(a_din),
        .bram_ready(ready), .cpu_hold(a_hold), .load_done(a_done), .load_error(a_err),
        .byte_count(a_bc), .checksum(a_cks));

    bram_loader #(.INDEX(8'd1), .HEADER_BYTES(2), .BASE_ADDR(16'h0100), .MAX_BYTES(513), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .ioctl_download(download), .ioctl_index(index),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(b_wait),
        .bram_download(b_bdl), .bram_wr(b_wr), .bram_init_address(b_addr), .bram_din(b_din),
        .bram_ready(ready), .cpu_hold(b_hold), .load_done(b_done), .load_error(b_err),
        .byte_count(b_bc), .checksum(b_cks));

    // Inputs change just after posedge, so negedge sees stable outputs and inputs.
    always @(negedge clk) begin
        if (a_wr && ready) wq_a.push_back({a_addr, a_din});
        if (b_wr && ready) wq_b.push_back({b_addr, b_din});
        if (a_done) done_a++;
        if (a_hold) hold_seen = 1'b1;
        if (a_wait) wait_seen = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq_a.delete();
        wq_b.delete();
        done_a    = 0;
        hold_seen = 1'b0;
        wait_seen = 1'b0;
    endtask

    task automatic start(input logic [7:0] idx);
        download = 1'b1;
        index    = idx;
        tick();
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int k;
        for (k = 0; k < 200; k++) begin
            if (!a_wait) break;
            tick();
        end
        if (k == 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ioctl_wait stuck at %0b want 0", a_wait);
        end
        wr   = 1'b1;
        addr = a;
        dout = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic finish_load();
        download = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_a > 0) break;
        end
        tick();
        tick();
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        int          exp_wr;
        logic [15:0] exp_addr;
        logic        exp_err;
        logic [15:0] exp_bc;
        logic [7:0]  exp_cks;
        int          exp_done;
        logic        exp_act;
    } vec_t;

    vec_t        vecs[6];
    logic [7:0]  d4[4];
    logic [7:0]  sum;
    int          first_wait;

    initial begin
        vecs[0] = '{8'd1, 25'd0,         8'h5A, 1, 16'h0000, 1'b0, 16'd1, 8'h5A, 1, 1'b1};
        vecs[1] = '{8'd2, 25'd5,         8'h77, 0, 16'h0000, 1'b0, 16'd1, 8'h5A, 0, 1'b0};
        vecs[2] = '{8'd1, 25'd512,       8'h01, 1, 16'h0200, 1'b0, 16'd1, 8'h01, 1, 1'b1};
        vecs[3] = '{8'd1, 25'd513,       8'h33, 0, 16'h0000, 1'b1, 16'd0, 8'h00, 1, 1'b1};
        vecs[4] = '{8'd1, 25'd100,       8'hFF, 1, 16'h0064, 1'b0, 16'd1, 8'hFF, 1, 1'b1};
        vecs[5] = '{8'd1, 25'h1FF_FFFF,  8'h12, 0, 16'h0000, 1'b1, 16'd0, 8'h00, 1, 1'b1};
        d4[0] = 8'h11; d4[1] = 8'h22; d4[2] = 8'h33; d4[3] = 8'h44;

        reset = 1'b1; download = 1'b0; index = 8'd0; wr = 1'b0;
        addr = '0; dout = '0; ready = 1'b1;
        #1;
        chk("reset_outs", {a_wait, a_bdl, a_wr, a_addr, a_din, a_hold, a_done, a_err, a_bc, a_cks}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            clear_mon();
            start(vecs[i].idx);
            send_byte(vecs[i].addr, vecs[i].data);
            finish_load();
            chk($sformatf("v%0d_nwr", i), wq_a.size(), vecs[i].exp_wr);
            if (wq_a.size() > 0 && vecs[i].exp_wr > 0)
                chk($sformatf("v%0d_entry", i), wq_a[0], {vecs[i].exp_addr, vecs[i].data});
            chk($sformatf("v%0d_err", i),  a_err, vecs[i].exp_err);
            chk($sformatf("v%0d_bc", i),   a_bc, vecs[i].exp_bc);
            chk($sformatf("v%0d_cks", i),  a_cks, vecs[i].exp_cks);
            chk($sformatf("v%0d_done", i), done_a, vecs[i].exp_done);
            chk($sformatf("v%0d_hold_seen", i), hold_seen, vecs[i].exp_act);
            chk($sformatf("v%0d_wait_seen", i), wait_seen, vecs[i].exp_act);
            chk($sformatf("v%0d_idle", i), {a_hold, a_bdl, a_wr}, 3'b000);
        end

        // Four-byte load; the header-stripping instance keeps only the last two.
        clear_mon();
        start(8'd1);
        for (int i = 0; i < 4; i++) send_byte(25'(i), d4[i]);
        finish_load();
        chk("ld4_nwr", wq_a.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < wq_a.size()) chk($sformatf("ld4_entry%0d", i), wq_a[i], {16'(i), d4[i]});
        chk("ld4_bc", a_bc, 16'd4);
        chk("ld4_cks", a_cks, 8'hAA);
        chk("ld4_done", done_a, 1);
        chk("ld4_hold_fell", a_hold, 1'b0);
        chk("hdr_nwr", wq_b.size(), 2);
        if (wq_b.size() == 2) begin
            chk("hdr_entry0", wq_b[0], {16'h0100, 8'h33});
            chk("hdr_entry1", wq_b[1], {16'h0101, 8'h44});
        end

        // Stalled BRAM with a continuous stream: sender must be held off, nothing lost.
        clear_mon();
        first_wait = -1;
        start(8'd1);
        ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    if (a_wait && first_wait < 0) first_wait = i;
                    send_byte(25'(i), 8'h80 + 8'(i));
                end
            end
            begin
                repeat (20) tick();
                ready = 1'b1;
            end
        join
        finish_load();
        chk("bp_wait_rise", (first_wait >= 1 && first_wait <= 3), 1'b1);
        chk("bp_nwr", wq_a.size(), 8);
        sum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sum = sum + 8'h80 + 8'(i);
            if (i < wq_a.size()) chk($sformatf("bp_entry%0d", i), wq_a[i], {16'(i), 8'h80 + 8'(i)});
        end
        chk("bp_err", a_err, 1'b0);
        chk("bp_bc", a_bc, 16'd8);
        chk("bp_cks", a_cks, sum);
        chk("bp_done", done_a, 1);

        // Reset mid-load with bytes queued, then a clean reload.
        clear_mon();
        start(8'd1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(25'(i), 8'(i + 1));
        tick();
        tick();
        chk("rst_pre_queued", {a_wr, a_hold}, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_outs", {a_wait, a_bdl, a_wr, a_addr, a_din, a_hold, a_done, a_err, a_bc, a_cks}, 64'd0);
        download = 1'b0;
        ready    = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_no_writes", wq_a.size(), 0);
        clear_mon();
        start(8'd1);
        for (int i = 0; i < 4; i++) send_byte(25'(i), d4[i]);
        finish_load();
        chk("reload_nwr", wq_a.size(), 4);
        chk("reload_bc", a_bc, 16'd4);
        chk("reload_cks", a_cks, 8'hAA);
        chk("reload_done", done_a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
